key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Conditions the raw active-low DE1 pushbuttons before they reach temp_input and top-level control.
//  For each key it does:
//   - 2-FF synchronisation to clk
//   - per-key debounce
//   - single-cycle press and release strobes
//   - auto-repeat strobes while the key is held
//  Its outputs replace the raw ~KEY[n] terms feeding the enter and reset logic.
// PARAMETERS
//  NUM_KEYS         4           number of independent key channels
//  DEBOUNCE_CYCLES  250000      stable cycles needed to accept a level change (5 ms @ 50 MHz); >=2
//  HOLD_CYCLES      50000000    cycles from the accepted press to the first repeat strobe (1 s); >=2
//  REPEAT_CYCLES    10000000    cycles between later repeat strobes (200 ms); >=2
// PORTS
//  clk          in   1         system clock (CLOCK_50)
//  rst          in   1         asynchronous, active-low reset
//  key_n_in     in   NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk
//  key_level    out  NUM_KEYS  debounced level, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle strobe when a press is accepted
//  key_release  out  NUM_KEYS  1-cycle strobe when a release is accepted
//  key_repeat   out  NUM_KEYS  1-cycle strobe for each auto-repeat while held
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - sync flops = 1 (released); all FSMs = IDLE; all counters = 0
//   - key_level, key_press, key_release, key_repeat = 0
//   - a reset mid-debounce or mid-hold discards the pending event; no strobe is issued
//  Sync: 2-FF chain per key, reset value 1. Every later stage uses only the second flop (s).
//  Per-key FSM, one per channel, all independent:
//   IDLE:     s=0 -> DB_PRESS, cnt=1.
//   DB_PRESS: s=0 and cnt==DEBOUNCE_CYCLES-1 -> HELD. Same edge: key_level<=1, key_press<=1 for one cycle, hcnt=0.
//             s=0 otherwise -> cnt++.
//             s=1 (bounce) -> IDLE, cnt=0. No strobe.
//   HELD:     s=1 -> DB_REL, cnt=1.
//             Otherwise hcnt++. When hcnt==HOLD_CYCLES-1: key_repeat<=1 for one cycle -> RPT, hcnt=0.
//   RPT:      s=1 -> DB_REL, cnt=1.
//             Otherwise hcnt++. When hcnt==REPEAT_CYCLES-1: key_repeat<=1 for one cycle, hcnt=0.
//   DB_REL:   s=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Same edge: key_level<=0, key_release<=1 for one cycle.
//             s=1 otherwise -> cnt++.
//             s=0 (bounce) -> return to the state DB_REL was entered from. hcnt is held, not cleared.
//  Latency:
//   - raw edge, held stable, to press/release strobe = 2 (sync) + DEBOUNCE_CYCLES cycles
//   - accepted press to first key_repeat = HOLD_CYCLES cycles
//   - repeat to repeat = REPEAT_CYCLES cycles
//  Exclusivity: key_press, key_repeat and key_release never assert in the same cycle on one channel.
//   - no repeat fires while in DB_REL
//   - the hold count is frozen during DB_REL
//  Strobes are registered outputs. key_level changes on the same edge as its press/release strobe.
//  Counter widths: $clog2 of the largest relevant parameter. Counters saturate, never wrap.
//  Simultaneous events on different channels are fully independent; all strobes may coincide.
//  A glitch shorter than DEBOUNCE_CYCLES produces no output change.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, NUM_KEYS=4)
//  1 Reset: hold rst=0, toggle key_n_in -> all outputs 0. Release rst -> outputs stay 0 while key_n_in=4'hF.
//  2 Clean press: key_n_in[0] 1->0 at cycle t, held -> key_press[0] high only at t+6; key_level[0]=1 from t+6.
//  3 Bounce: key_n_in[1]=0 for 2 cycles, then 1 -> no strobe, key_level[1] stays 0.
//    Then low for 4 or more cycles -> exactly one key_press[1].
//  4 Hold/repeat: hold key 2 for 30 cycles after key_press[2] at T -> key_repeat[2] at T+10, T+13, T+16, ...;
//    release -> one key_release[2] and no further repeat.
//  5 Release bounce: during hold, key_n_in[3] high for 2 cycles, then low -> no release strobe;
//    repeat schedule resumes with hcnt preserved.
//  6 Concurrency and reset: press keys 0 and 3 in the same cycle -> both key_press strobes in the same cycle.
//    Assert rst mid-hold -> outputs 0 immediately; no release strobe after reset deasserts while keys are high.

Source files
------------

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-FF sync, debounce, press/release strobes and auto-repeat.
// Every output is registered, and each channel is independent of the others.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HC_W     = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] RPT_LAST  = HC_W'(REPEAT_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_HELD,
        S_RPT,
        S_DB_REL
    } keyState_t;

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;

    // Reset value 1 means "released", so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        keyState_t       r_state, w_nextState;
        logic [DB_W-1:0] r_cnt, w_nextCnt;
        logic [HC_W-1:0] r_hcnt, w_nextHcnt;
        logic            r_fromRpt, w_nextFromRpt;
        logic            r_level, w_nextLevel;
        logic            r_press, r_release, r_repeat;
        logic            w_press, w_release, w_repeat;
        logic            w_s;

        assign w_s = r_sync2[g];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_hcnt    <= '0;
                r_fromRpt <= 1'b0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_state   <= w_nextState;
                r_cnt     <= w_nextCnt;
                r_hcnt    <= w_nextHcnt;
                r_fromRpt <= w_nextFromRpt;
                r_level   <= w_nextLevel;
                r_press   <= w_press;
                r_release <= w_release;
                r_repeat  <= w_repeat;
            end
        end

        // A bounce during release debounce resumes HELD/RPT with the hold count untouched.
        always_comb begin
            w_nextState   = r_state;
            w_nextCnt     = r_cnt;
            w_nextHcnt    = r_hcnt;
            w_nextFromRpt = r_fromRpt;
            w_nextLevel   = r_level;
            w_press       = 1'b0;
            w_release     = 1'b0;
            w_repeat      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_s) begin
                        w_nextState = S_DB_PRESS;
                        w_nextCnt   = DB_ONE;
                    end
                end
                S_DB_PRESS: begin
                    if (w_s) begin
                        w_nextState = S_IDLE;
                        w_nextCnt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_nextState = S_HELD;
                        w_nextCnt   = '0;
                        w_nextHcnt  = '0;
                        w_nextLevel = 1'b1;
                        w_press     = 1'b1;
                    end else begin
                        w_nextCnt = (r_cnt == '1) ? r_cnt : r_cnt + DB_ONE;
                    end
                end
                S_HELD, S_RPT: begin
                    if (w_s) begin
                        w_nextState   = S_DB_REL;
                        w_nextCnt     = DB_ONE;
                        w_nextFromRpt = (r_state == S_RPT);
                    end else if (r_hcnt == ((r_state == S_RPT) ? RPT_LAST : HOLD_LAST)) begin
                        w_nextState = S_RPT;
                        w_nextHcnt  = '0;
                        w_repeat    = 1'b1;
                    end else begin
                        w_nextHcnt = (r_hcnt == '1) ? r_hcnt : r_hcnt + HC_ONE;
                    end
                end
                S_DB_REL: begin
                    if (!w_s) begin
                        w_nextState = r_fromRpt ? S_RPT : S_HELD;
                        w_nextCnt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_nextState = S_IDLE;
                        w_nextCnt   = '0;
                        w_nextLevel = 1'b0;
                        w_release   = 1'b1;
                    end else begin
                        w_nextCnt = (r_cnt == '1) ? r_cnt : r_cnt + DB_ONE;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_nextCnt   = '0;
                    w_nextHcnt  = '0;
                end
            endcase
        end

        assign key_level[g]   = r_level;
        assign key_press[g]   = r_press;
        assign key_release[g] = r_release;
        assign key_repeat[g]  = r_repeat;
    end

endmodule
